// File: rtl/uart_tx_arb_pkg.sv
// Shared definitions for the UART TX FIFO write-port arbiter.
//   uart_arb_state_e : arbiter state encoding (IDLE = arbitrate, LOCK = packet owned)
//   UART_ARB_TIMEOUT : default idle-cycle limit before a locked grant is revoked
//   UART_ARB_TO_W    : default timeout counter width
package uart_tx_arb_pkg;

  typedef enum logic {
    UART_ARB_IDLE = 1'b0,
    UART_ARB_LOCK = 1'b1
  } uart_arb_state_e;

  localparam int unsigned UART_ARB_TIMEOUT = 200;
  localparam int unsigned UART_ARB_TO_W    = 8;

endpackage

// File: rtl/uart_tx_arb_rr_arb_pick.sv
// rr_arb_pick: combinational round-robin priority picker.
//   vld [NREQ]  : request vector
//   ptr [PTR_W] : first index searched; the search wraps past NREQ-1 to 0
//   gnt [NREQ]  : one-hot grant of the first valid request at or after ptr, 0 if none
module rr_arb_pick #(
  parameter int unsigned NREQ  = 2,
  parameter int unsigned PTR_W = 1
) (
  input  logic [NREQ-1:0]  vld,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  gnt
);

  logic found;

  // Outer loop walks priority order; the inner loop only ever indexes with a
  // loop constant, so exactly one candidate matches each priority slot.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (!found && vld[i] && (((32'(ptr) + off) % NREQ) == i)) begin
          gnt[i] = 1'b1;
          found  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin arbiter sharing the UART TX FIFO write port between
// NREQ byte-stream requesters. A grant is held for a whole packet (through the
// beat flagged last); a stalled owner is revoked after TIMEOUT idle cycles.
//   clk, rst            : clock, synchronous active-high reset
//   req_vld/req_rdy     : per-requester byte handshake (req_rdy combinational)
//   req_data            : requester i byte on [8i+7:8i]
//   req_last            : current byte ends the packet
//   fifowrfull          : TX FIFO full
//   fifowrreq/fifowdata : registered one-cycle FIFO write pulse and data
//   grant_o             : one-hot current owner, 0 when idle
//   busy                : a grant is locked
//   to_evt              : one-cycle pulse when a grant is revoked by timeout
module uart_tx_arb
  import uart_tx_arb_pkg::*;
#(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned TO_W    = UART_ARB_TO_W,
  parameter int unsigned TIMEOUT = UART_ARB_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_vld,
  output logic [NREQ-1:0]   req_rdy,
  input  logic [NREQ*8-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  input  logic              fifowrfull,
  output logic              fifowrreq,
  output logic [7:0]        fifowdata,
  output logic [NREQ-1:0]   grant_o,
  output logic              busy,
  output logic              to_evt
);

  localparam int unsigned     PTR_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT);

  uart_arb_state_e state, state_d;
  logic [PTR_W-1:0] ptr, ptr_d;
  logic [TO_W-1:0]  cnt, cnt_d;
  logic [NREQ-1:0]  grant_d, pick_gnt;
  logic             busy_d, wr_d;
  logic [7:0]       wdata_d;

  logic [PTR_W-1:0] owner_idx, next_ptr;
  logic [7:0]       owner_data;
  logic             owner_vld, owner_last, accept;

  rr_arb_pick #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .vld (req_vld),
    .ptr (ptr),
    .gnt (pick_gnt)
  );

  // The write gap (~fifowrreq) limits throughput to one byte every two
  // cycles, which is what makes a full flag raised after a write safe.
  always_comb begin
    req_rdy = '0;
    if (state == UART_ARB_LOCK) begin
      req_rdy = grant_o & {NREQ{~fifowrfull & ~fifowrreq}};
    end
  end

  always_comb begin
    owner_idx  = '0;
    owner_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant_o[i]) begin
        owner_idx  = PTR_W'(i);
        owner_data = req_data[8*i +: 8];
      end
    end
  end

  assign owner_vld  = |(req_vld & grant_o);
  assign owner_last = |(req_last & grant_o);
  assign accept     = |(req_vld & req_rdy);
  assign next_ptr   = (owner_idx == PTR_W'(NREQ - 1)) ? '0 : owner_idx + 1'b1;

  always_comb begin
    state_d = state;
    grant_d = grant_o;
    busy_d  = busy;
    ptr_d   = ptr;
    cnt_d   = cnt;
    wr_d    = 1'b0;
    wdata_d = fifowdata;
    to_evt  = 1'b0;
    case (state)
      UART_ARB_IDLE: begin
        if (|req_vld) begin
          grant_d = pick_gnt;
          busy_d  = 1'b1;
          state_d = UART_ARB_LOCK;
        end
      end
      UART_ARB_LOCK: begin
        // Accept is checked first so a beat arriving on the limit cycle wins
        // over the revoke.
        if (accept) begin
          wr_d    = 1'b1;
          wdata_d = owner_data;
          cnt_d   = '0;
          if (owner_last) begin
            state_d = UART_ARB_IDLE;
            grant_d = '0;
            busy_d  = 1'b0;
            ptr_d   = next_ptr;
          end
        end else if (cnt == TO_LIM) begin
          to_evt  = 1'b1;
          state_d = UART_ARB_IDLE;
          grant_d = '0;
          busy_d  = 1'b0;
          ptr_d   = next_ptr;
          cnt_d   = '0;
        end else if (!owner_vld) begin
          // Only an absent owner ages the grant; FIFO backpressure holds it.
          cnt_d = cnt + 1'b1;
        end
      end
      default: state_d = UART_ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= UART_ARB_IDLE;
      grant_o   <= '0;
      busy      <= 1'b0;
      ptr       <= '0;
      cnt       <= '0;
      fifowrreq <= 1'b0;
      fifowdata <= '0;
    end else begin
      state     <= state_d;
      grant_o   <= grant_d;
      busy      <= busy_d;
      ptr       <= ptr_d;
      cnt       <= cnt_d;
      fifowrreq <= wr_d;
      fifowdata <= wdata_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
module tb_uart_tx_arb;

  logic       clk;
  logic       rst;
  logic [1:0] req_vld;
  logic [1:0] req_rdy;
  logic [15:0] req_data;
  logic [1:0] req_last;
  logic       fifowrfull;
  logic       fifowrreq;
  logic [7:0] fifowdata;
  logic [1:0] grant_o;
  logic       busy;
  logic       to_evt;

  uart_tx_arb #(
    .NREQ    (2),
    .TO_W    (8),
    .TIMEOUT (200)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .req_vld    (req_vld),
    .req_rdy    (req_rdy),
    .req_data   (req_data),
    .req_last   (req_last),
    .fifowrfull (fifowrfull),
    .fifowrreq  (fifowrreq),
    .fifowdata  (fifowdata),
    .grant_o    (grant_o),
    .busy       (busy),
    .to_evt     (to_evt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;

  // Source queues: {last, data}; hold forces req_vld low.
  logic [8:0] q0[$];
  logic [8:0] q1[$];
  logic       hold0 = 1'b0;
  logic       hold1 = 1'b0;

  // Monitor logs
  int         cyc = 0;
  logic [7:0] wr_data[$];
  int         wr_cyc[$];
  logic       wr_busy[$];
  logic [1:0] gnt_log[$];
  int         gnt_cyc[$];
  int         to_cnt = 0;
  int         to_cyc = 0;
  logic [1:0] last_gnt = 2'b00;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (fifowrreq === 1'b1) begin
      wr_data.push_back(fifowdata);
      wr_cyc.push_back(cyc);
      wr_busy.push_back(busy);
    end
    if (to_evt === 1'b1) begin
      to_cnt <= to_cnt + 1;
      to_cyc <= cyc;
    end
    if (grant_o !== last_gnt) begin
      gnt_log.push_back(grant_o);
      gnt_cyc.push_back(cyc);
      last_gnt <= grant_o;
    end
  end

  // Requester model: handshake sampled mid-cycle, pop/drive just after the edge.
  initial begin
    logic [1:0] acc;
    req_vld  = '0;
    req_data = '0;
    req_last = '0;
    forever begin
      @(negedge clk);
      acc = req_vld & req_rdy;
      @(posedge clk);
      #1;
      if (acc[0] && q0.size() != 0) void'(q0.pop_front());
      if (acc[1] && q1.size() != 0) void'(q1.pop_front());
      req_vld[0]    = !hold0 && (q0.size() != 0);
      req_data[7:0] = (q0.size() != 0) ? q0[0][7:0] : 8'h00;
      req_last[0]   = (q0.size() != 0) ? q0[0][8] : 1'b0;
      req_vld[1]    = !hold1 && (q1.size() != 0);
      req_data[15:8] = (q1.size() != 0) ? q1[0][7:0] : 8'h00;
      req_last[1]   = (q1.size() != 0) ? q1[0][8] : 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_logs();
    wr_data.delete();
    wr_cyc.delete();
    wr_busy.delete();
    gnt_log.delete();
    gnt_cyc.delete();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic wait_writes(input int n, input bit need_idle, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (wr_data.size() >= n && (!need_idle || busy === 1'b0)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    fifowrfull = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    tests++; if (fifowrreq !== 1'b0) begin failed++; $display("FAIL reset_wrreq: got %b expected 0", fifowrreq); end
    tests++; if (fifowdata !== 8'h00) begin failed++; $display("FAIL reset_wdata: got %h expected 00", fifowdata); end
    tests++; if (grant_o !== 2'b00) begin failed++; $display("FAIL reset_grant: got %b expected 00", grant_o); end
    tests++; if (busy !== 1'b0) begin failed++; $display("FAIL reset_busy: got %b expected 0", busy); end
    tests++; if (to_evt !== 1'b0) begin failed++; $display("FAIL reset_to_evt: got %b expected 0", to_evt); end
    tests++; if (req_rdy !== 2'b00) begin failed++; $display("FAIL reset_rdy: got %b expected 00", req_rdy); end
    tests++; if (u_dut.ptr !== 1'b0) begin failed++; $display("FAIL reset_ptr: got %b expected 0", u_dut.ptr); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_single_packet();
    bit ok;
    @(negedge clk); #1;
    clear_logs();
    q0.push_back({1'b0, 8'h48});
    q0.push_back({1'b0, 8'h69});
    q0.push_back({1'b1, 8'h0A});
    wait_writes(3, 1'b1, 40, ok);
    tests++; if (ok !== 1'b1) begin failed++; $display("FAIL single_done: got %b expected 1", ok); end
    tests++; if (wr_data[0] !== 8'h48) begin failed++; $display("FAIL single_b0: got %h expected 48", wr_data[0]); end
    tests++; if (wr_data[1] !== 8'h69) begin failed++; $display("FAIL single_b1: got %h expected 69", wr_data[1]); end
    tests++; if (wr_data[2] !== 8'h0A) begin failed++; $display("FAIL single_b2: got %h expected 0a", wr_data[2]); end
    tests++; if (wr_cyc[1] - wr_cyc[0] != 2) begin failed++; $display("FAIL single_gap1: got %0d expected 2", wr_cyc[1] - wr_cyc[0]); end
    tests++; if (wr_cyc[2] - wr_cyc[1] != 2) begin failed++; $display("FAIL single_gap2: got %0d expected 2", wr_cyc[2] - wr_cyc[1]); end
    tests++; if (gnt_log[0] !== 2'b01) begin failed++; $display("FAIL single_grant: got %b expected 01", gnt_log[0]); end
    tests++; if (wr_cyc[0] - gnt_cyc[0] != 1) begin failed++; $display("FAIL single_lat: got %0d expected 1", wr_cyc[0] - gnt_cyc[0]); end
    tests++; if (wr_busy[1] !== 1'b1) begin failed++; $display("FAIL single_busy_mid: got %b expected 1", wr_busy[1]); end
    tests++; if (wr_busy[2] !== 1'b0) begin failed++; $display("FAIL single_busy_end: got %b expected 0", wr_busy[2]); end
    tests++; if (u_dut.ptr !== 1'b1) begin failed++; $display("FAIL single_ptr: got %b expected 1", u_dut.ptr); end
  endtask

  task automatic test_contention();
    bit ok;
    do_reset();
    @(negedge clk); #1;
    clear_logs();
    q0.push_back({1'b0, 8'h41});
    q0.push_back({1'b1, 8'h42});
    q1.push_back({1'b0, 8'h61});
    q1.push_back({1'b1, 8'h62});
    wait_writes(4, 1'b1, 60, ok);
    tests++; if (ok !== 1'b1) begin failed++; $display("FAIL cont_done: got %b expected 1", ok); end
    tests++; if ({wr_data[0], wr_data[1], wr_data[2], wr_data[3]} !== 32'h41426162) begin
      failed++; $display("FAIL cont_order: got %h %h %h %h expected 41 42 61 62", wr_data[0], wr_data[1], wr_data[2], wr_data[3]);
    end
    tests++; if (gnt_log.size() != 4 || {gnt_log[0], gnt_log[1], gnt_log[2], gnt_log[3]} !== 8'b01_00_10_00) begin
      failed++; $display("FAIL cont_grants: got n=%0d %b %b %b %b expected 01 00 10 00", gnt_log.size(), gnt_log[0], gnt_log[1], gnt_log[2], gnt_log[3]);
    end
    tests++; if (wr_cyc[2] - wr_cyc[1] != 2) begin failed++; $display("FAIL cont_pkt_gap: got %0d expected 2", wr_cyc[2] - wr_cyc[1]); end
  endtask

  task automatic test_fairness();
    bit ok;
    logic [7:0] exp_d[6];
    logic [1:0] exp_g[6];
    logic [1:0] nz[$];
    exp_d[0] = 8'h10; exp_d[1] = 8'h20; exp_d[2] = 8'h11;
    exp_d[3] = 8'h21; exp_d[4] = 8'h12; exp_d[5] = 8'h13;
    exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01;
    exp_g[3] = 2'b10; exp_g[4] = 2'b01; exp_g[5] = 2'b01;
    @(negedge clk); #1;
    clear_logs();
    hold1 = 1'b1;
    for (int i = 0; i < 4; i++) q0.push_back({1'b1, 8'h10 + 8'(i)});
    q1.push_back({1'b1, 8'h20});
    q1.push_back({1'b1, 8'h21});
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      if (busy === 1'b1) begin ok = 1'b1; break; end
    end
    tests++; if (ok !== 1'b1) begin failed++; $display("FAIL fair_first_grant: got %b expected 1", ok); end
    hold1 = 1'b0;
    wait_writes(6, 1'b1, 80, ok);
    tests++; if (ok !== 1'b1) begin failed++; $display("FAIL fair_done: got %b expected 1", ok); end
    for (int i = 0; i < 6; i++) begin
      tests++; if (wr_data[i] !== exp_d[i]) begin failed++; $display("FAIL fair_data%0d: got %h expected %h", i, wr_data[i], exp_d[i]); end
    end
    foreach (gnt_log[i]) if (gnt_log[i] != 2'b00) nz.push_back(gnt_log[i]);
    tests++; if (nz.size() != 6) begin failed++; $display("FAIL fair_ngrants: got %0d expected 6", nz.size()); end
    for (int i = 0; i < 6; i++) begin
      tests++; if (nz[i] !== exp_g[i]) begin failed++; $display("FAIL fair_grant%0d: got %b expected %b", i, nz[i], exp_g[i]); end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int to_base;
    @(negedge clk); #1;
    clear_logs();
    to_base = to_cnt;
    q0.push_back({1'b0, 8'h31});
    q0.push_back({1'b0, 8'h32});
    q0.push_back({1'b1, 8'h33});
    wait_writes(1, 1'b0, 20, ok);
    tests++; if (ok !== 1'b1) begin failed++; $display("FAIL bp_first: got %b expected 1", ok); end
    @(posedge clk); #1;
    fifowrfull = 1'b1;
    repeat (500) @(negedge clk);
    #1;
    tests++; if (wr_data.size() != 1) begin failed++; $display("FAIL bp_nowrite: got %0d writes expected 1", wr_data.size()); end
    tests++; if (to_cnt - to_base != 0) begin failed++; $display("FAIL bp_no_to: got %0d expected 0", to_cnt - to_base); end
    tests++; if (grant_o !== 2'b01) begin failed++; $display("FAIL bp_grant: got %b expected 01", grant_o); end
    tests++; if (busy !== 1'b1) begin failed++; $display("FAIL bp_busy: got %b expected 1", busy); end
    @(posedge clk); #1;
    fifowrfull = 1'b0;
    wait_writes(3, 1'b1, 20, ok);
    tests++; if (ok !== 1'b1) begin failed++; $display("FAIL bp_resume: got %b expected 1", ok); end
    tests++; if ({wr_data[1], wr_data[2]} !== 16'h3233) begin failed++; $display("FAIL bp_data: got %h %h expected 32 33", wr_data[1], wr_data[2]); end
    tests++; if (to_cnt - to_base != 0) begin failed++; $display("FAIL bp_no_to_end: got %0d expected 0", to_cnt - to_base); end
  endtask

  task automatic test_timeout();
    bit ok;
    int to_base;
    int w;
    do_reset();
    @(negedge clk); #1;
    clear_logs();
    to_base = to_cnt;
    q0.push_back({1'b0, 8'h55});
    q1.push_back({1'b1, 8'h77});
    wait_writes(1, 1'b0, 20, ok);
    tests++; if (ok !== 1'b1) begin failed++; $display("FAIL to_first: got %b expected 1", ok); end
    ok = 1'b0;
    for (int i = 0; i < 260; i++) begin
      @(negedge clk); #1;
      if (to_cnt - to_base >= 1) begin ok = 1'b1; break; end
    end
    tests++; if (ok !== 1'b1) begin failed++; $display("FAIL to_seen: got %b expected 1", ok); end
    tests++; if (to_cyc - wr_cyc[0] != 200) begin failed++; $display("FAIL to_delay: got %0d expected 200", to_cyc - wr_cyc[0]); end
    wait_writes(2, 1'b1, 20, ok);
    tests++; if (ok !== 1'b1) begin failed++; $display("FAIL to_next_pkt: got %b expected 1", ok); end
    tests++; if (wr_data[1] !== 8'h77) begin failed++; $display("FAIL to_next_data: got %h expected 77", wr_data[1]); end
    tests++; if (to_cnt - to_base != 1) begin failed++; $display("FAIL to_pulse_len: got %0d expected 1", to_cnt - to_base); end
    tests++; if (gnt_log.size() != 4 || {gnt_log[0], gnt_log[1], gnt_log[2], gnt_log[3]} !== 8'b01_00_10_00) begin
      failed++; $display("FAIL to_grants: got n=%0d %b %b %b %b expected 01 00 10 00", gnt_log.size(), gnt_log[0], gnt_log[1], gnt_log[2], gnt_log[3]);
    end
    tests++; if (gnt_cyc[2] - to_cyc != 2) begin failed++; $display("FAIL to_regrant: got %0d expected 2", gnt_cyc[2] - to_cyc); end

    // Accept arriving on the cycle the counter sits at the limit.
    do_reset();
    @(negedge clk); #1;
    clear_logs();
    to_base = to_cnt;
    q0.push_back({1'b0, 8'h61});
    wait_writes(1, 1'b0, 20, ok);
    tests++; if (ok !== 1'b1) begin failed++; $display("FAIL race_first: got %b expected 1", ok); end
    w = wr_cyc[0];
    for (int i = 0; i < 300; i++) begin
      if (cyc >= w + 199) break;
      @(negedge clk); #1;
    end
    q0.push_back({1'b1, 8'h62});
    wait_writes(2, 1'b1, 20, ok);
    tests++; if (ok !== 1'b1) begin failed++; $display("FAIL race_done: got %b expected 1", ok); end
    tests++; if (to_cnt - to_base != 0) begin failed++; $display("FAIL race_no_to: got %0d expected 0", to_cnt - to_base); end
    tests++; if (wr_cyc[1] - w != 201) begin failed++; $display("FAIL race_wr_cyc: got %0d expected 201", wr_cyc[1] - w); end
    tests++; if (wr_data[1] !== 8'h62) begin failed++; $display("FAIL race_data: got %h expected 62", wr_data[1]); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    @(negedge clk); #1;
    clear_logs();
    q1.push_back({1'b0, 8'hB1});
    q1.push_back({1'b0, 8'hB2});
    q1.push_back({1'b1, 8'hB3});
    wait_writes(1, 1'b0, 20, ok);
    tests++; if (ok !== 1'b1) begin failed++; $display("FAIL rmid_first: got %b expected 1", ok); end
    tests++; if (grant_o !== 2'b10) begin failed++; $display("FAIL rmid_owner: got %b expected 10", grant_o); end
    hold0 = 1'b1;
    hold1 = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk); #1;
    tests++; if (fifowrreq !== 1'b0) begin failed++; $display("FAIL rmid_wrreq: got %b expected 0", fifowrreq); end
    tests++; if (fifowdata !== 8'h00) begin failed++; $display("FAIL rmid_wdata: got %h expected 00", fifowdata); end
    tests++; if (grant_o !== 2'b00) begin failed++; $display("FAIL rmid_grant: got %b expected 00", grant_o); end
    tests++; if (busy !== 1'b0) begin failed++; $display("FAIL rmid_busy: got %b expected 0", busy); end
    tests++; if (u_dut.ptr !== 1'b0) begin failed++; $display("FAIL rmid_ptr: got %b expected 0", u_dut.ptr); end
    q0.delete();
    q1.delete();
    clear_logs();
    q0.push_back({1'b1, 8'hC1});
    q1.push_back({1'b1, 8'hD1});
    hold0 = 1'b0;
    hold1 = 1'b0;
    wait_writes(2, 1'b1, 30, ok);
    tests++; if (ok !== 1'b1) begin failed++; $display("FAIL rmid_after: got %b expected 1", ok); end
    tests++; if (gnt_log[0] !== 2'b01) begin failed++; $display("FAIL rmid_first_grant: got %b expected 01", gnt_log[0]); end
    tests++; if ({wr_data[0], wr_data[1]} !== 16'hC1D1) begin failed++; $display("FAIL rmid_order: got %h %h expected c1 d1", wr_data[0], wr_data[1]); end
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_contention();
    test_fairness();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
